// File: rtl/simple_pkg.sv
// Shared types and defaults for the SIMPLE 16-bit core front end.
package simple_pkg;
    localparam int          ADDR_W_DEF   = 16;
    localparam int          DATA_W_DEF   = 16;
    localparam logic [15:0] NOP_INST_DEF = 16'hC0E0;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for an instruction word (and its fetch address)
// that returns from memory while the decoder is stalled.
module fetch_skid_buf
    import simple_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_unload,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_data,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W-1:0] o_pc
);
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_pc    <= i_pc;
        end else if (i_unload) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_pc    = r_pc;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the 1-cycle synchronous imem and
// presents one registered instruction per cycle to the decoder.
module fetch_stage
    import simple_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [DATA_W-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              halt_n_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              inst_valid_o,
    output logic              halted_o
);
    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pend_pc;
    logic              r_pend;
    logic [DATA_W-1:0] r_inst;
    logic [ADDR_W-1:0] r_pc_o;
    logic              r_valid;
    logic              r_halted;

    logic              w_run;
    logic              w_flush;
    logic              w_issue;
    logic              w_skid_load;
    logic              w_skid_unload;
    logic              w_skid_v;
    logic [DATA_W-1:0] w_skid_data;
    logic [ADDR_W-1:0] w_skid_pc;

    assign w_run         = (r_state == RUN);
    assign w_flush       = w_run && (!halt_n_i || redirect_i);
    assign w_issue       = w_run && halt_n_i && !redirect_i && !stall_i;
    // A word returning into a stall parks in the skid; it drains first once the stall lifts.
    assign w_skid_load   = w_run && !w_flush && stall_i && r_pend;
    assign w_skid_unload = w_run && !w_flush && !stall_i && w_skid_v;

    assign imem_en      = w_issue;
    assign imem_addr    = r_pc;
    assign inst_o       = r_inst;
    assign pc_o         = r_pc_o;
    assign inst_valid_o = r_valid;
    assign halted_o     = r_halted;

    fetch_skid_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_flush  (w_flush),
        .i_data   (imem_rdata),
        .i_pc     (r_pend_pc),
        .o_valid  (w_skid_v),
        .o_data   (w_skid_data),
        .o_pc     (w_skid_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= BOOT;
            r_pc      <= RESET_PC;
            r_pend_pc <= '0;
            r_pend    <= 1'b0;
            r_inst    <= NOP_INST;
            r_pc_o    <= '0;
            r_valid   <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            case (r_state)
                BOOT: r_state <= RUN;
                RUN: begin
                    if (!halt_n_i) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                        r_pend   <= 1'b0;
                        r_inst   <= NOP_INST;
                        r_valid  <= 1'b0;
                    end else if (redirect_i) begin
                        r_pc    <= redirect_pc_i;
                        r_pend  <= 1'b0;
                        r_inst  <= NOP_INST;
                        r_valid <= 1'b0;
                    end else begin
                        r_pend <= w_issue;
                        if (w_issue) begin
                            r_pend_pc <= r_pc;
                            r_pc      <= r_pc + PC_ONE;
                        end
                        if (!stall_i) begin
                            if (w_skid_v) begin
                                r_inst  <= w_skid_data;
                                r_pc_o  <= w_skid_pc + PC_ONE;
                                r_valid <= 1'b1;
                            end else if (r_pend) begin
                                r_inst  <= imem_rdata;
                                r_pc_o  <= r_pend_pc + PC_ONE;
                                r_valid <= 1'b1;
                            end else begin
                                r_inst  <= NOP_INST;
                                r_valid <= 1'b0;
                            end
                        end
                    end
                end
                HALT:    r_state <= HALT;
                default: r_state <= BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage; the model tracks issued
// addresses as a lossless in-order stream that redirect/halt/reset discard.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'h0;
    logic        stall_i;
    logic        redirect_i;
    logic [15:0] redirect_pc_i;
    logic        halt_n_i;
    logic [15:0] inst_o;
    logic [15:0] pc_o;
    logic        inst_valid_o;
    logic        halted_o;

    logic        rst2;
    logic        en2;
    logic [15:0] addr2;
    logic [15:0] rdata2 = 16'h0;
    logic        stall2 = 1'b0;
    logic        redir2 = 1'b0;
    logic [15:0] rpc2   = 16'h0;
    logic        hn2    = 1'b1;
    logic [15:0] inst2;
    logic [15:0] pco2;
    logic        v2;
    logic        h2;

    localparam logic [15:0] NOP = 16'hC0E0;

    always #5 clk = ~clk;

    fetch_stage u_dut (
        .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .halt_n_i(halt_n_i), .inst_o(inst_o),
        .pc_o(pc_o), .inst_valid_o(inst_valid_o), .halted_o(halted_o)
    );

    fetch_stage #(.RESET_PC(16'hFFFE)) u_dut_wrap (
        .clk(clk), .rst(rst2), .imem_en(en2), .imem_addr(addr2),
        .imem_rdata(rdata2), .stall_i(stall2), .redirect_i(redir2),
        .redirect_pc_i(rpc2), .halt_n_i(hn2), .inst_o(inst2),
        .pc_o(pco2), .inst_valid_o(v2), .halted_o(h2)
    );

    // Memory contents: (a+1)*0x1111, a bijection so every address has a distinct word.
    function automatic logic [15:0] word(input logic [15:0] a);
        logic [15:0] t;
        t = a + 16'd1;
        return t * 16'h1111;
    endfunction

    always @(posedge clk) if (imem_en) imem_rdata <= word(imem_addr);
    always @(posedge clk) if (en2) rdata2 <= word(addr2);

    typedef struct {
        logic [15:0] inst;
        logic [15:0] pc;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] inflight[$];
    int          m_state;   // 0 boot, 1 run, 2 halt
    logic [15:0] m_pc;
    bit          m_halted;
    int          total = 0;
    int          bad   = 0;
    bit          mon_st;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every non-stalled edge either delivers the scoreboard head or a bubble.
    always begin
        @(posedge clk);
        mon_st = stall_i && !rst;
        @(negedge clk);
        if (!mon_st) begin
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("valid", 16'(inst_valid_o), 16'h1);
                chk("inst", inst_o, e.inst);
                chk("pc_o", pc_o, e.pc);
            end else begin
                chk("bubble_valid", 16'(inst_valid_o), 16'h0);
                chk("bubble_inst", inst_o, NOP);
            end
        end
        chk("halted", 16'(halted_o), 16'(m_halted));
    end

    task automatic step(input bit s, input bit r, input logic [15:0] rpc, input bit hn);
        stall_i = s; redirect_i = r; redirect_pc_i = rpc; halt_n_i = hn;
        #1;
        chk("imem_en", 16'(imem_en), 16'(m_state == 1 && !s && !r && hn && !rst));
        if (m_state == 1 && !rst) chk("imem_addr", imem_addr, m_pc);
        @(posedge clk);
        if (!rst) begin
            case (m_state)
                0: m_state = 1;
                1: begin
                    if (!hn) begin
                        inflight.delete();
                        m_state  = 2;
                        m_halted = 1'b1;
                    end else if (r) begin
                        inflight.delete();
                        m_pc = rpc;
                    end else if (!s) begin
                        if (inflight.size() > 0) begin
                            logic [15:0] a;
                            a = inflight.pop_front();
                            sb_q.push_back('{inst: word(a), pc: a + 16'd1});
                        end
                        inflight.push_back(m_pc);
                        m_pc = m_pc + 16'd1;
                    end
                end
                default: ;
            endcase
        end
        #1;
    endtask

    task automatic model_reset();
        inflight.delete();
        sb_q.delete();
        m_state  = 0;
        m_pc     = 16'h0000;
        m_halted = 1'b0;
    endtask

    task automatic async_reset(input bit hold_stall);
        #2 rst = 1'b1;
        #1;
        chk("rst_inst", inst_o, NOP);
        chk("rst_valid", 16'(inst_valid_o), 16'h0);
        chk("rst_pc_o", pc_o, 16'h0);
        chk("rst_halted", 16'(halted_o), 16'h0);
        chk("rst_en", 16'(imem_en), 16'h0);
        model_reset();
        repeat (2) step(hold_stall, 1'b0, 16'h0, 1'b1);
        #2 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 16'h0; halt_n_i = 1'b1;
        model_reset();
        #1;
        chk("init_inst", inst_o, NOP);
        chk("init_valid", 16'(inst_valid_o), 16'h0);
        chk("init_pc_o", pc_o, 16'h0);
        chk("init_en", 16'(imem_en), 16'h0);
        @(posedge clk); @(posedge clk);
        #3 rst = 1'b0;

        // boot, straight-line fetch of 1111..4444
        repeat (6) step(1'b0, 1'b0, 16'h0, 1'b1);
        // stall while a word is returning, then resume
        repeat (3) step(1'b1, 1'b0, 16'h0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 16'h0, 1'b1);
        // redirect while stalled
        step(1'b1, 1'b0, 16'h0, 1'b1);
        step(1'b1, 1'b1, 16'h0040, 1'b1);
        repeat (5) step(1'b0, 1'b0, 16'h0, 1'b1);
        // halt and redirect together
        step(1'b0, 1'b1, 16'h0080, 1'b0);
        repeat (4) step(1'b0, 1'b0, 16'h0, 1'b1);
        repeat (2) step(1'b0, 1'b1, 16'h0010, 1'b1);
        async_reset(1'b0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit          s, r, hn;
            logic [15:0] t;
            if (m_halted && $urandom_range(0, 3) == 0) async_reset(1'($urandom_range(0, 1)));
            s  = ($urandom_range(0, 9) < 3);
            r  = ($urandom_range(0, 99) < 6);
            hn = ($urandom_range(0, 99) >= 2);
            t  = 16'($urandom);
            if ($urandom_range(0, 2) == 0) t = 16'hFFFD;
            step(s, r, t, hn);
        end
        if (m_halted) async_reset(1'b0);

        // reset mid-stall with the skid full
        repeat (4) step(1'b0, 1'b0, 16'h0, 1'b1);
        repeat (3) step(1'b1, 1'b0, 16'h0, 1'b1);
        async_reset(1'b1);
        repeat (6) step(1'b0, 1'b0, 16'h0, 1'b1);
        repeat (2) step(1'b0, 1'b1, 16'h0, 1'b1);
        chk("sb_drained", 16'(sb_q.size()), 16'h0);

        // RESET_PC = FFFE wrap, main core parked in reset
        #2 rst = 1'b1;
        model_reset();
        #3 rst2 = 1'b0;
        @(posedge clk); #1;
        chk("wrap_en", 16'(en2), 16'h1);
        chk("wrap_addr0", addr2, 16'hFFFE);
        @(posedge clk); #1;
        chk("wrap_addr1", addr2, 16'hFFFF);
        @(posedge clk); #1;
        chk("wrap_inst0", inst2, word(16'hFFFE));
        chk("wrap_pc0", pco2, 16'hFFFF);
        chk("wrap_addr2", addr2, 16'h0000);
        @(posedge clk); #1;
        chk("wrap_inst1", inst2, word(16'hFFFF));
        chk("wrap_pc1", pco2, 16'h0000);
        @(posedge clk); #1;
        chk("wrap_inst2", inst2, word(16'h0000));
        chk("wrap_pc2", pco2, 16'h0001);
        chk("wrap_valid", 16'(v2), 16'h1);

        @(negedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
